// File: rtl/sample_frame_serializer.sv
// -----------------------------------------------------------------------------
// sample_frame_serializer
//
// Buffers decimated samples from the CIC stage in a small FIFO and, on each
// rising edge of trigger, sends one framed packet on serial_out. The packet is
// a 16-bit header followed by every buffered sample, all sent MSB first.
//
// Header layout: [15:12]=4'b1010, [11:8]=CHAN_ID, [7]=overflow at frame start,
//                [6:4]=0, [3:0]=number of data words in the frame.
//
// Optional feature (macro FRAME_CRC_EN): when defined, a CRC-8 follows the
// payload. The polynomial is 0x07 with init 0x00, no reflection and no final
// XOR. It covers every header and data bit, MSB first.
//
// Parameters:
//   WIDTH    sample width, fixed at 16 by the frame format
//   DEPTH    FIFO depth in words (2, 4 or 8)
//   CHAN_ID  4-bit channel tag placed in the header
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   sample_in     decimated sample
//   sample_valid  one-cycle strobe qualifying sample_in
//   trigger       frame request, rising edge only
//   serial_out    registered serial frame bit
//   frame_valid   high during the first header bit of a frame
//   busy          high from frame start until the end of the gap
//   overflow      sticky, a sample was dropped since the last frame start
//   fill          current FIFO occupancy
// -----------------------------------------------------------------------------
module sample_frame_serializer #(
    parameter int         WIDTH   = 16,
    parameter int         DEPTH   = 8,
    parameter logic [3:0] CHAN_ID = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic                   sample_valid,
    input  logic                   trigger,
    output logic                   serial_out,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);
    localparam logic [3:0]        LAST_BIT = 4'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
`ifdef FRAME_CRC_EN
    localparam logic [2:0] S_CRC    = 3'd4;
`endif

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] count;

    logic [2:0]        state;
    logic              trig_q;
    logic [WIDTH-1:0]  sr;
    logic [3:0]        bit_cnt;
    logic [FILL_W-1:0] words_left;

    logic              push;
    logic              pop;
    logic              drop;
    logic              start;
    logic [15:0]       header_word;
    logic [WIDTH-1:0]  head_word;

    // The full test uses the count before the edge, so a pop in the same
    // cycle cannot make room for an incoming sample.
    assign push  = sample_valid && (count != FULL_CNT);
    assign drop  = sample_valid && (count == FULL_CNT);
    assign start = (state == S_IDLE) && trigger && !trig_q;

    // The next word is popped on the edge that puts its MSB on the pin. That
    // edge follows the last bit of the header or of the previous word.
    assign pop = ((state == S_HEADER) || (state == S_DATA)) &&
                 (bit_cnt == LAST_BIT) && (words_left != '0);

    assign header_word = {4'b1010, CHAN_ID, overflow, 3'b000, 4'(count)};
    assign head_word   = mem[rd_ptr];

    assign busy = (state != S_IDLE);
    assign fill = count;

    // FIFO storage. The storage has no reset because the pointers alone
    // define which words are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy. When a push and a pop happen in the same
    // cycle, the count stays the same.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FRAME_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // The CRC advances in step with each header or data bit placed on the
    // pin. After the payload it becomes a shift register that feeds the
    // remainder out MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (start) begin
            crc <= crc_step(8'h00, header_word[15]);
        end else if ((state == S_HEADER) || (state == S_DATA)) begin
            if (bit_cnt != LAST_BIT) begin
                crc <= crc_step(crc, sr[WIDTH-1]);
            end else if (pop) begin
                crc <= crc_step(crc, head_word[WIDTH-1]);
            end else begin
                crc <= {crc[6:0], 1'b0};
            end
        end else if (state == S_CRC) begin
            crc <= {crc[6:0], 1'b0};
        end
    end
`endif

    // Frame sequencer. serial_out is loaded with the bit to show in the next
    // cycle. sr holds the bits of the current word that have not been sent
    // yet. bit_cnt counts bits within a word, CRC bits, or gap cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            trig_q      <= 1'b0;
            sr          <= '0;
            bit_cnt     <= '0;
            words_left  <= '0;
            serial_out  <= 1'b0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            trig_q      <= trigger;
            frame_valid <= 1'b0;

            // A frame start clears the sticky flag. A drop in the same
            // cycle sets it again.
            if (start) begin
                overflow <= drop;
            end else if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    serial_out <= 1'b0;
                    if (start) begin
                        serial_out  <= header_word[15];
                        sr          <= {header_word[14:0], 1'b0};
                        frame_valid <= 1'b1;
                        bit_cnt     <= '0;
                        words_left  <= count;
                        state       <= S_HEADER;
                    end
                end

                S_HEADER, S_DATA: begin
                    if (bit_cnt != LAST_BIT) begin
                        serial_out <= sr[WIDTH-1];
                        sr         <= {sr[WIDTH-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + 4'd1;
                    end else if (pop) begin
                        serial_out <= head_word[WIDTH-1];
                        sr         <= {head_word[WIDTH-2:0], 1'b0};
                        bit_cnt    <= '0;
                        words_left <= words_left - FILL_W'(1);
                        state      <= S_DATA;
                    end else begin
                        bit_cnt <= '0;
`ifdef FRAME_CRC_EN
                        serial_out <= crc[7];
                        state      <= S_CRC;
`else
                        serial_out <= 1'b0;
                        state      <= S_GAP;
`endif
                    end
                end

`ifdef FRAME_CRC_EN
                S_CRC: begin
                    if (bit_cnt != 4'd7) begin
                        serial_out <= crc[7];
                        bit_cnt    <= bit_cnt + 4'd1;
                    end else begin
                        serial_out <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= S_GAP;
                    end
                end
`endif

                S_GAP: begin
                    serial_out <= 1'b0;
                    if (bit_cnt == 4'd1) begin
                        bit_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                default: begin
                    serial_out <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_sample_frame_serializer
//
// Directed testbench for sample_frame_serializer (DEPTH=8, CHAN_ID=0).
// The expected frame words are written by hand for each scenario. When
// FRAME_CRC_EN is defined, the expected CRC-8 comes from a bit-serial
// reference computed over those words.
// -----------------------------------------------------------------------------
module tb_sample_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        trigger;
    logic        serial_out;
    logic        frame_valid;
    logic        busy;
    logic        overflow;
    logic [3:0]  fill;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [15:0] expWords[$];

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    sample_frame_serializer #(
        .WIDTH   (16),
        .DEPTH   (8),
        .CHAN_ID (4'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trigger      (trigger),
        .serial_out   (serial_out),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .overflow     (overflow),
        .fill         (fill)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one sample with a one-cycle valid strobe
    task automatic applyStimulus(input logic [15:0] value);
        sample_in    = value;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Reference CRC-8 (poly 0x07, init 0) over all expected frame bits
    function automatic logic [7:0] crcModel();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (expWords[w]) begin
            for (int b = 15; b >= 0; b--) begin
                fb = c[7] ^ expWords[w][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // Scenario-specific input activity during a frame, keyed by bit index
    task automatic midAction(input int mode, input int idx);
        if (mode == 1) begin
            if (idx == 15) begin
                sample_in = 16'h3333; sample_valid = 1'b1;
            end
            if (idx == 16) begin
                sample_valid = 1'b0;
                checkOutput("retrig_fill_pushpop0", fill, 2);
            end
            if (idx == 20) trigger = 1'b0;
            if (idx == 22) trigger = 1'b1;
            if (idx == 31) begin
                sample_in = 16'h4444; sample_valid = 1'b1;
            end
            if (idx == 32) begin
                sample_valid = 1'b0;
                checkOutput("retrig_fill_pushpop1", fill, 2);
            end
        end else if (mode == 2) begin
            if (idx == 15) begin
                sample_in = 16'hDEAD; sample_valid = 1'b1;
            end
            if (idx == 16) begin
                sample_valid = 1'b0;
                checkOutput("ovf_fullpop_flag", overflow, 1);
                checkOutput("ovf_fullpop_fill", fill, 7);
            end
        end
    endtask

    // Trigger a frame, collect it word by word, then check the gap and idle
    task automatic captureFrame(input string tag, input int mode);
        logic [15:0] word;
        logic [7:0]  crcWord;
        logic        strayValid;
        logic        busyLow;
        int          idx;
        strayValid = 1'b0;
        busyLow    = 1'b0;
        idx        = 0;
        trigger    = 1'b1;
        tick();
        if (mode != 1) trigger = 1'b0;
        checkOutput({tag, "_fv_first"}, frame_valid, 1);
        checkOutput({tag, "_busy_start"}, busy, 1);
        checkOutput({tag, "_ovf_cleared"}, overflow, 0);
        for (int w = 0; w < expWords.size(); w++) begin
            word = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                word = {word[14:0], serial_out};
                if (idx != 0 && frame_valid) strayValid = 1'b1;
                if (!busy) busyLow = 1'b1;
                midAction(mode, idx);
                idx++;
                tick();
            end
            checkOutput($sformatf("%s_word%0d", tag, w), word, expWords[w]);
        end
`ifdef FRAME_CRC_EN
        crcWord = 8'h00;
        for (int b = 0; b < 8; b++) begin
            crcWord = {crcWord[6:0], serial_out};
            if (frame_valid) strayValid = 1'b1;
            if (!busy) busyLow = 1'b1;
            tick();
        end
        checkOutput({tag, "_crc"}, crcWord, crcModel());
`else
        crcWord = 8'h00;
`endif
        checkOutput({tag, "_fv_only_first"}, strayValid, crcWord & 8'h00);
        checkOutput({tag, "_busy_frame"}, busyLow, 0);
        checkOutput({tag, "_gap0"}, {busy, serial_out}, 2'b10);
        tick();
        checkOutput({tag, "_gap1"}, {busy, serial_out}, 2'b10);
        tick();
        checkOutput({tag, "_idle"}, {busy, serial_out, frame_valid}, 3'b000);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        logic sawBusy;
        rst          = 1'b1;
        trigger      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;

        // Power-on reset
        tick();
        tick();
        checkOutput("reset_serial", serial_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_fill", fill, 0);
        checkOutput("reset_ovf", overflow, 0);
        checkOutput("reset_fv", frame_valid, 0);
        rst = 1'b0;
        tick();

        // Reset during a frame with a pending drop
        for (int i = 0; i < 8; i++) applyStimulus(16'hA5A0 + 16'(i));
        checkOutput("midrst_fill_full", fill, 8);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        tick();
        sample_in    = 16'hFFFF;
        sample_valid = 1'b1;
        tick();
        checkOutput("midrst_ovf_before", overflow, 1);
        checkOutput("midrst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_serial", serial_out, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ovf", overflow, 0);
        checkOutput("midrst_fill", fill, 0);
        checkOutput("midrst_fv", frame_valid, 0);
        tick();
        rst          = 1'b0;
        sample_valid = 1'b0;
        tick();
        checkOutput("midrst_after_busy", busy, 0);

        // Basic three-word frame
        applyStimulus(16'h1234);
        applyStimulus(16'hBEEF);
        applyStimulus(16'h0001);
        checkOutput("basic_fill", fill, 3);
        expWords = '{16'hA003, 16'h1234, 16'hBEEF, 16'h0001};
        captureFrame("basic", 0);
        checkOutput("basic_fill_after", fill, 0);

        // Empty FIFO: header only, 16 bits plus 2 gap cycles of busy
        expWords = '{16'hA000};
        captureFrame("empty", 0);

        // Overflow: 10 pushes into 8 slots, plus a push on a pop edge
        for (int i = 0; i < 10; i++) applyStimulus(16'h0100 + 16'(i));
        checkOutput("ovf_fill", fill, 8);
        checkOutput("ovf_flag", overflow, 1);
        expWords = '{16'hA088, 16'h0100, 16'h0101, 16'h0102, 16'h0103,
                     16'h0104, 16'h0105, 16'h0106, 16'h0107};
        captureFrame("ovf", 2);
        checkOutput("ovf_fill_after", fill, 0);
        checkOutput("ovf_flag_after", overflow, 1);

        // Held trigger with a mid-frame re-pulse and concurrent pushes
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        expWords = '{16'hA082, 16'h1111, 16'h2222};
        captureFrame("retrig", 1);
        checkOutput("retrig_fill_idle", fill, 2);
        sawBusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) sawBusy = 1'b1;
            tick();
        end
        checkOutput("retrig_single_frame", sawBusy, 0);
        trigger = 1'b0;
        tick();

        // Samples pushed during the previous frame form the next one
        expWords = '{16'hA002, 16'h3333, 16'h4444};
        captureFrame("follow", 0);
        checkOutput("follow_fill_after", fill, 0);

`ifdef FRAME_CRC_EN
        // Single zero word with CRC trailer
        applyStimulus(16'h0000);
        expWords = '{16'hA001, 16'h0000};
        captureFrame("crc", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sample_frame_serializer.md
Name: sample_frame_serializer

Overview:
- Downstream consumer of the per-channel CIC decimator output.
- Buffers decimated 16-bit samples in a small FIFO.
- On an external trigger edge, emits one framed serial packet on a single output pin: header, then every buffered sample MSB-first, optionally followed by a CRC.
- Replaces the single-word snapshot serialisation: no samples are lost between triggers, up to DEPTH of them.

Parameters:
- WIDTH, 16, sample word width in bits; fixed at 16 for the frame format.
- DEPTH, 8, FIFO depth in words; legal values 2, 4, 8 (count must fit the 4-bit header field).
- CHAN_ID, 4'h0, 4-bit channel tag inserted in the header.

Ports:
- clk  in  1  system clock; everything is in this domain
- rst  in  1  synchronous, active-high reset
- sample_in  in  WIDTH  decimated sample from the CIC stage
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle
- trigger  in  1  frame request; only the rising edge is used
- serial_out  out  1  registered serial frame bit
- frame_valid  out  1  high only during the first header bit of a frame
- busy  out  1  high from frame start until the end of the gap
- overflow  out  1  sticky flag: a sample was dropped since the last frame start
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: serial_out=0, frame_valid=0, busy=0, overflow=0, fill=0. FSM goes to IDLE, FIFO pointers are cleared, trigger edge register=0.
- Reset mid-frame aborts the frame immediately; the next cycle shows reset values.
- FIFO write: on sample_valid when not full, the word is written and fill increments next cycle.
- FIFO full: sample_valid while full drops the new word and sets overflow.
  - A pop in the same cycle does not free a slot for that write. The full check uses the pre-edge count.
- Edge detect: trig_q registers trigger. A rising edge is trigger=1 && trig_q=0 at a clk edge.
  - Edges outside IDLE are ignored.
  - A trigger held high produces only one frame.
- FSM states: IDLE -> HEADER -> DATA -> [CRC] -> GAP -> IDLE.
- IDLE:
  - serial_out=0, busy=0.
  - On a rising edge: latch N=fill and OVF=overflow, clear overflow (new drops in the same cycle still set it), load the header shift register, go to HEADER.
  - serial_out shows header bit 15 in the cycle after the detecting edge, with frame_valid=1 and busy=1.
- HEADER: 16 bits, MSB first, one bit per clk.
  - Header layout: [15:12]=4'b1010, [11:8]=CHAN_ID, [7]=OVF, [6:4]=0, [3:0]=N.
  - After bit 0: go to DATA if N>0, otherwise to CRC/GAP.
- DATA:
  - For each of the N words: pop the FIFO head into the shift register; the pop takes effect on the edge that loads that word's bit 15.
  - Shift 16 bits MSB first, words back-to-back with no idle cycles.
  - Exactly N words are sent; samples written during the frame stay in the FIFO for the next frame.
- GAP: serial_out=0 for 2 cycles with busy=1, then IDLE. Minimum trigger-to-trigger spacing is therefore the frame length plus 2 cycles.
- Frame length in bits: 16*(N+1), plus 8 when CRC is enabled.
- Simultaneous push and pop: both happen; fill is unchanged.
- fill never exceeds DEPTH.

Optional Feature:
- Macro: FRAME_CRC_EN.
- Defined:
  - CRC state is active; a CRC-8 follows the last data bit (or the header if N=0).
  - CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed MSB-first over every header and data bit; the 8 CRC bits are sent MSB first, then GAP.
- Not defined: no CRC logic or state; DATA (or HEADER) goes directly to GAP.

Test Plan:
- Reset: assert rst for 2 cycles during activity -> serial_out=0, busy=0, overflow=0, fill=0 on the cycle after reset.
- Basic frame, CHAN_ID=0, CRC off: push 0x1234, 0xBEEF, 0x0001, then pulse trigger -> header 0xA003, then 0x1234, 0xBEEF, 0x0001 serially, 64 bits total; frame_valid high only on the first bit; then 2 gap cycles; fill=0 afterwards.
- Overflow: push 10 samples with DEPTH=8 -> fill=8, overflow=1; trigger -> header 0xA088 and the first 8 samples; overflow=0 after frame start.
- Empty FIFO: trigger with fill=0 -> header 0xA000 only, 16 bits; busy for 18 cycles.
- Retrigger and concurrent push: hold trigger high across the frame, pulse it again mid-frame, and push 2 samples mid-frame -> exactly one frame; N stays as latched; fill=2 at return to IDLE.
- FRAME_CRC_EN defined: push 0x0000, trigger -> header 0xA001, data 0x0000, then the 8 CRC bits; the bench reference model must compute them per the rules above.
